// File: rtl/gyro_pkg.sv
// Shared FSM encoding and default parameter values for the gyro rate integrator.
package gyro_pkg;

    typedef enum logic [1:0] {
        ST_CAL  = 2'd0,
        ST_BIAS = 2'd1,
        ST_RUN  = 2'd2
    } gyro_state_e;

    localparam int GYRO_NUM_CH    = 3;
    localparam int GYRO_DATA_W    = 16;
    localparam int GYRO_ACC_W     = 48;
    localparam int GYRO_CAL_LOG2  = 8;
    localparam int GYRO_OUT_SHIFT = 28;
    localparam int GYRO_DEADBAND  = 200;

endpackage

// File: rtl/gyro_channel.sv
// One rate channel: bias subtract + deadband into a stage-1 register, then a
// saturating accumulator with a sticky saturation flag.
module gyro_channel #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 48,
    parameter int OUT_SHIFT = 28,
    parameter int DEADBAND  = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              run,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] bias,
    output logic              upd,
    output logic              sat,
    output logic [DATA_W-1:0] angle
);
    localparam logic [DATA_W:0]  DB      = (DATA_W+1)'(DEADBAND);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [DATA_W:0]  diff, mag, d_db, d_q;
    logic [ACC_W:0]   sum_w;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic             s1_valid, ovf;

    // One extra bit on both the difference and the sum so overflow is visible.
    always_comb begin
        diff    = {sample[DATA_W-1], sample} - {bias[DATA_W-1], bias};
        mag     = diff[DATA_W] ? -diff : diff;
        d_db    = (mag <= DB) ? '0 : diff;
        sum_w   = {acc[ACC_W-1], acc} + {{(ACC_W-DATA_W){d_q[DATA_W]}}, d_q};
        ovf     = sum_w[ACC_W] ^ sum_w[ACC_W-1];
        acc_nxt = ovf ? (sum_w[ACC_W] ? ACC_MIN : ACC_MAX) : sum_w[ACC_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            d_q      <= '0;
            acc      <= '0;
            sat      <= 1'b0;
            upd      <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (clr) begin
                s1_valid <= 1'b0;
                acc      <= '0;
                sat      <= 1'b0;
            end else begin
                s1_valid <= run && sample_valid;
                if (run && sample_valid)
                    d_q <= d_db;
                if (s1_valid) begin
                    acc <= acc_nxt;
                    upd <= 1'b1;
                    if (ovf)
                        sat <= 1'b1;
                end
            end
        end
    end

    assign angle = acc[OUT_SHIFT +: DATA_W];

endmodule

// File: rtl/gyro_integrator.sv
// Multi-channel gyro integrator: averages 2^CAL_LOG2 samples into a bias,
// then integrates bias-corrected, deadbanded rates per channel.
module gyro_integrator
    import gyro_pkg::*;
#(
    parameter int NUM_CH    = GYRO_NUM_CH,
    parameter int DATA_W    = GYRO_DATA_W,
    parameter int ACC_W     = GYRO_ACC_W,
    parameter int CAL_LOG2  = GYRO_CAL_LOG2,
    parameter int OUT_SHIFT = GYRO_OUT_SHIFT,
    parameter int DEADBAND  = GYRO_DEADBAND
) (
    input  logic                     clk,
    input  logic                     system_reset,
    input  logic                     rate_valid,
    input  logic [NUM_CH*DATA_W-1:0] rate_data,
    input  logic                     angle_reset,
    input  logic                     recal,
    output logic [NUM_CH*DATA_W-1:0] angle_data,
    output logic                     angle_valid,
    output logic                     calibrated,
    output logic [NUM_CH-1:0]        sat_flag
);
    localparam int SUM_W = DATA_W + CAL_LOG2;

    gyro_state_e                      state, state_nxt;
    logic [CAL_LOG2-1:0]              cnt;
    logic [NUM_CH-1:0][SUM_W-1:0]     sums;
    logic [NUM_CH-1:0][DATA_W-1:0]    bias;
    logic [NUM_CH-1:0]                upd_v;
    logic                             run, clr;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CAL:  if (rate_valid && (&cnt)) state_nxt = ST_BIAS;
            ST_BIAS: state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_CAL;
        endcase
        if (recal)
            state_nxt = ST_CAL;
    end

    // Counter wraps to zero on the last calibration sample.
    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) begin
            state <= ST_CAL;
            cnt   <= '0;
            sums  <= '0;
            bias  <= '0;
        end else begin
            state <= state_nxt;
            if (recal) begin
                cnt  <= '0;
                sums <= '0;
                bias <= '0;
            end else if (state == ST_CAL && rate_valid) begin
                cnt <= cnt + CAL_LOG2'(1);
                for (int i = 0; i < NUM_CH; i++)
                    sums[i] <= sums[i] + SUM_W'($signed(rate_data[i*DATA_W +: DATA_W]));
            end else if (state == ST_BIAS) begin
                for (int i = 0; i < NUM_CH; i++)
                    bias[i] <= sums[i][CAL_LOG2 +: DATA_W];
            end
        end
    end

    assign run        = (state == ST_RUN);
    assign clr        = angle_reset || recal;
    assign calibrated = run;
    assign angle_valid = &upd_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        gyro_channel #(
            .DATA_W   (DATA_W),
            .ACC_W    (ACC_W),
            .OUT_SHIFT(OUT_SHIFT),
            .DEADBAND (DEADBAND)
        ) u_ch (
            .clk         (clk),
            .rst         (system_reset),
            .clr         (clr),
            .run         (run),
            .sample_valid(rate_valid),
            .sample      (rate_data[i*DATA_W +: DATA_W]),
            .bias        (bias[i]),
            .upd         (upd_v[i]),
            .sat         (sat_flag[i]),
            .angle       (angle_data[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_gyro_integrator.sv
// Directed bench: two integrators (default, and ACC_W=18/OUT_SHIFT=2) share one
// stimulus stream and are checked every cycle against an integer model.
module tb_gyro_integrator;

    localparam int NCH   = 3;
    localparam int DW    = 16;
    localparam int NCAL  = 256;

    logic             clk = 1'b0;
    logic             system_reset = 1'b1;
    logic             rate_valid = 1'b0;
    logic [NCH*DW-1:0] rate_data = '0;
    logic             angle_reset = 1'b0;
    logic             recal = 1'b0;

    logic [NCH*DW-1:0] angle_a, angle_b;
    logic              av_a, av_b, cal_a, cal_b;
    logic [NCH-1:0]    sat_a, sat_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gyro_integrator dut_a (
        .clk(clk), .system_reset(system_reset), .rate_valid(rate_valid),
        .rate_data(rate_data), .angle_reset(angle_reset), .recal(recal),
        .angle_data(angle_a), .angle_valid(av_a), .calibrated(cal_a), .sat_flag(sat_a)
    );

    gyro_integrator #(.ACC_W(18), .OUT_SHIFT(2)) dut_b (
        .clk(clk), .system_reset(system_reset), .rate_valid(rate_valid),
        .rate_data(rate_data), .angle_reset(angle_reset), .recal(recal),
        .angle_data(angle_b), .angle_valid(av_b), .calibrated(cal_b), .sat_flag(sat_b)
    );

    // ---------------- behavioural model ----------------
    int     m_phase = 0;   // 0 calibrating, 1 bias cycle, 2 running
    int     m_cnt   = 0;
    longint m_sum [NCH];
    longint m_bias[NCH];
    longint m_pd  [NCH];
    bit     m_pv  = 0;
    bit     m_av  = 0;
    longint m_acc [2][NCH];
    bit     m_sat [2][NCH];
    int     accw  [2] = '{48, 18};
    int     shft  [2] = '{28, 2};

    function automatic longint smp(input logic [NCH*DW-1:0] v, input int i);
        logic [DW-1:0] t;
        t = v[i*DW +: DW];
        return longint'($signed(t));
    endfunction

    always @(posedge clk or posedge system_reset) begin
        if (system_reset || recal) begin
            m_phase = 0; m_cnt = 0; m_pv = 0; m_av = 0;
            for (int i = 0; i < NCH; i++) begin
                m_sum[i] = 0; m_bias[i] = 0; m_pd[i] = 0;
                for (int d = 0; d < 2; d++) begin m_acc[d][i] = 0; m_sat[d][i] = 0; end
            end
        end else begin
            m_av = 0;
            if (angle_reset) begin
                m_pv = 0;
                for (int i = 0; i < NCH; i++)
                    for (int d = 0; d < 2; d++) begin m_acc[d][i] = 0; m_sat[d][i] = 0; end
            end else if (m_pv) begin
                m_pv = 0;
                m_av = 1;
                for (int d = 0; d < 2; d++) begin
                    longint hi, t;
                    hi = (longint'(1) <<< (accw[d] - 1)) - 1;
                    for (int i = 0; i < NCH; i++) begin
                        t = m_acc[d][i] + m_pd[i];
                        if (t > hi) begin t = hi; m_sat[d][i] = 1; end
                        if (t < -hi - 1) begin t = -hi - 1; m_sat[d][i] = 1; end
                        m_acc[d][i] = t;
                    end
                end
            end
            case (m_phase)
                0: if (rate_valid) begin
                    for (int i = 0; i < NCH; i++) m_sum[i] += smp(rate_data, i);
                    m_cnt++;
                    if (m_cnt == NCAL) begin m_phase = 1; m_cnt = 0; end
                end
                1: begin
                    for (int i = 0; i < NCH; i++) m_bias[i] = m_sum[i] >>> 8;
                    m_phase = 2;
                end
                default: if (rate_valid && !angle_reset) begin
                    for (int i = 0; i < NCH; i++) begin
                        m_pd[i] = smp(rate_data, i) - m_bias[i];
                        if (m_pd[i] >= -200 && m_pd[i] <= 200) m_pd[i] = 0;
                    end
                    m_pv = 1;
                end
            endcase
        end
    end

    function automatic logic [NCH*DW-1:0] exp_ang(input int d);
        logic [NCH*DW-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*DW +: DW] = DW'(m_acc[d][i] >>> shft[d]);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_sat(input int d);
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_sat[d][i];
        return v;
    endfunction

    function automatic longint lane(input logic [NCH*DW-1:0] v, input int i);
        logic [DW-1:0] t;
        t = v[i*DW +: DW];
        return longint'(t);
    endfunction

    function automatic logic [NCH*DW-1:0] pack3(input int a, input int b, input int c);
        return {DW'(c), DW'(b), DW'(a)};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("av_a",  longint'(av_a),  longint'(m_av));
        chk("av_b",  longint'(av_b),  longint'(m_av));
        chk("cal_a", longint'(cal_a), longint'(m_phase == 2));
        chk("cal_b", longint'(cal_b), longint'(m_phase == 2));
        chk("sat_a", longint'(sat_a), longint'(exp_sat(0)));
        chk("sat_b", longint'(sat_b), longint'(exp_sat(1)));
        chk("ang_a", longint'(angle_a), longint'(exp_ang(0)));
        chk("ang_b", longint'(angle_b), longint'(exp_ang(1)));
    endtask

    task automatic drive(input bit v, input logic [NCH*DW-1:0] d,
                         input bit ar = 1'b0, input bit rc = 1'b0);
        rate_valid = v; rate_data = d; angle_reset = ar; recal = rc;
        cyc();
    endtask

    task automatic reset_now();
        system_reset = 1'b1;
        #1;
        chk("rst_cal",   longint'(cal_b),   0);
        chk("rst_av",    longint'(av_b),    0);
        chk("rst_ang_b", longint'(angle_b), 0);
        chk("rst_sat_b", longint'(sat_b),   0);
        drive(0, '0);
        system_reset = 1'b0;
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        system_reset = 1'b0;
        cyc();
        chk("init_cal", longint'(cal_a), 0);
        chk("init_ang", longint'(angle_a), 0);

        // reset during calibration discards the partial sums
        repeat (100) drive(1, pack3(100, 100, 100));
        reset_now();
        repeat (NCAL - 1) drive(1, pack3(100, 100, 100));
        chk("cal_255", longint'(cal_a), 0);
        drive(1, pack3(100, 100, 100));
        chk("bias_cycle_cal", longint'(cal_a), 0);
        drive(0, '0);
        chk("run_cal", longint'(cal_a), 1);
        chk("model_bias", m_bias[0], 100);

        // latency and deadband edges, bias 100
        drive(1, pack3(400, 100, -150));
        chk("lat_av0", longint'(av_b), 0);
        drive(0, '0);
        chk("lat_av1", longint'(av_b), 1);
        chk("lat_ang", lane(angle_b, 0), 75);
        drive(1, pack3(300, 301, -100));
        drive(0, '0);
        chk("db_200", lane(angle_b, 0), 75);
        chk("db_201", lane(angle_b, 1), 50);

        // recal beats angle_reset; recal inside CAL restarts the count
        drive(0, '0, 1, 1);
        chk("recal_cal", longint'(cal_a), 0);
        repeat (100) drive(1, pack3(7, 7, 7));
        drive(1, pack3(7, 7, 7), 0, 1);
        repeat (NCAL) drive(1, pack3(0, 0, 0));
        drive(0, '0);
        chk("bias0_cal", longint'(cal_a), 1);

        // bias 0: inside deadband, then just outside
        drive(1, pack3(150, 150, 150));
        drive(0, '0);
        chk("db150_av", longint'(av_b), 1);
        chk("db150_ang", lane(angle_b, 0), 0);
        drive(1, pack3(201, 201, 201));
        chk("s201_av0", longint'(av_b), 0);
        drive(0, '0);
        chk("s201_av1", longint'(av_b), 1);
        chk("s201_ang", lane(angle_b, 0), 50);

        // sample coincident with angle_reset is dropped
        drive(1, pack3(1000, 1000, 1000), 1, 0);
        chk("ar_ang", longint'(angle_b), 0);
        drive(0, '0);
        chk("ar_av", longint'(av_b), 0);
        drive(0, '0);

        // saturation both ways on the narrow accumulator, back-to-back samples
        repeat (5) drive(1, pack3(32767, -32768, 32767));
        drive(0, '0);
        chk("sat_flags_b", longint'(sat_b), 7);
        chk("sat_flags_a", longint'(sat_a), 0);
        chk("sat_pos", lane(angle_b, 0), 'h7FFF);
        chk("sat_neg", lane(angle_b, 1), 'h8000);
        chk("model_sat", m_acc[1][0], 131071);
        drive(0, '0, 1, 0);
        chk("sat_clr", longint'(sat_b), 0);
        chk("sat_clr_ang", longint'(angle_b), 0);

        // async reset with the pipeline full
        repeat (3) drive(1, pack3(5000, 5000, 5000));
        reset_now();
        repeat (3) drive(0, '0);

        // negative bias; a sample in the bias cycle is dropped
        repeat (NCAL) drive(1, pack3(-50, -50, -50));
        drive(1, pack3(-300, -300, -300));
        drive(1, pack3(-300, -300, -300));
        drive(0, '0);
        chk("neg_ang_a", lane(angle_a, 0), 'hFFFF);
        chk("neg_ang_b", lane(angle_b, 0), 'hFFC1);
        chk("model_neg", m_acc[1][0], -250);
        repeat (2) drive(0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gyro_integrator.md
GYRO_INTEGRATOR -- requirements
Module: gyro_integrator

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of rate channels.
REQ-002 SHALL have parameter DATA_W, default 16: signed sample and angle width.
REQ-003 SHALL have parameter ACC_W, default 48: signed accumulator width; OUT_SHIFT+DATA_W <= ACC_W.
REQ-004 SHALL have parameter CAL_LOG2, default 8: calibration length is 2^CAL_LOG2 accepted samples.
REQ-005 SHALL have parameter OUT_SHIFT, default 28: accumulator-to-angle right shift.
REQ-006 SHALL have parameter DEADBAND, default 200: unsigned magnitude below which the bias-corrected rate is zeroed.
REQ-007 SHALL have port clk  in  1  rising-edge clock.
REQ-008 SHALL have port system_reset  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-009 SHALL have port rate_valid  in  1  sample strobe; one sample accepted per high cycle.
REQ-010 SHALL have port rate_data  in  NUM_CH*DATA_W  packed signed rates, ch0 in LSBs.
REQ-011 SHALL have port angle_reset  in  1  synchronous clear of accumulators and saturation flags.
REQ-012 SHALL have port recal  in  1  synchronous restart of calibration.
REQ-013 SHALL have port angle_data  out  NUM_CH*DATA_W  packed signed angles.
REQ-014 SHALL have port angle_valid  out  1  one-cycle pulse per accumulator update.
REQ-015 SHALL have port calibrated  out  1  high while in RUN.
REQ-016 SHALL have port sat_flag  out  NUM_CH  sticky per-channel saturation indicator.

Function
REQ-017 SHALL implement FSM states CAL, BIAS, RUN; CAL is the state after reset.
REQ-018 CAL: each accepted sample SHALL be sign-extended and added to a per-channel sum of width DATA_W+CAL_LOG2 (no wrap possible); counter increments per sample.
REQ-019 On the 2^CAL_LOG2-th accepted sample, CAL SHALL go to BIAS; exactly 2^CAL_LOG2 samples are summed.
REQ-020 BIAS SHALL last one cycle: bias = sum arithmetically shifted right by CAL_LOG2 (signed, truncating toward minus infinity); then RUN; samples during BIAS are dropped.
REQ-021 RUN stage 1: on rate_valid, d = sample - bias computed at DATA_W+1 signed bits; if |d| <= DEADBAND, d = 0; d and a valid bit registered.
REQ-022 RUN stage 2: on registered valid, acc += sign-extended d, saturating at signed ACC_W max/min; angle_valid pulses in the same registered cycle.
REQ-023 Latency: sample accepted at edge k -> angle_data updated and angle_valid high after edge k+1; throughput one sample per cycle.
REQ-024 On saturation, acc SHALL clamp and sat_flag[ch] SHALL set and hold until angle_reset, recal or system_reset.
REQ-025 angle_data per channel SHALL equal bits [OUT_SHIFT+DATA_W-1:OUT_SHIFT] of acc.
REQ-026 angle_valid, stage-1 register and angle_data changes SHALL NOT occur outside RUN.
REQ-027 angle_reset SHALL clear acc, sat_flag and the stage-1 valid; a sample coincident with angle_reset is dropped; bias is kept.
REQ-028 recal SHALL override angle_reset: clear sums, counter, bias, acc, sat_flag, stage-1 valid; go to CAL; calibrated low next cycle.
REQ-029 recal asserted in CAL SHALL restart calibration from zero samples.

Reset
REQ-030 system_reset SHALL asynchronously force: state CAL, counter/sums/bias/acc 0, angle_data 0, angle_valid 0, calibrated 0, sat_flag 0, stage-1 valid 0.
REQ-031 Reset mid-calibration or mid-pipeline SHALL discard all partial state; no angle_valid until a full recalibration completes.

Structure
REQ-032 Package gyro_pkg SHALL hold the FSM state enumeration and default parameter constants.
REQ-033 Sub-module gyro_channel (bias subtract, deadband, stage-1 register, saturating accumulator, sat flag) SHALL be instantiated NUM_CH times by generate; the top holds FSM, counter and sums.

Verification
REQ-034 Defaults, 256 samples all channels 100 -> bias 100, calibrated high after BIAS cycle, zero angle_valid during CAL.
REQ-035 Bias 0: sample 150 -> acc unchanged, angle_valid pulses; sample 201 -> acc 201, angle_valid 2 edges after strobe.
REQ-036 Calibrate at -50 (0xFFCE), then sample -300 -> d -250, acc -250; angle_data reads 0xFFFF (sign-preserved shift).
REQ-037 ACC_W=18, OUT_SHIFT=2, bias 0: five samples 32767 -> acc 131071, sat_flag=1, angle 0x7FFF; angle_reset -> acc 0, sat_flag 0.
REQ-038 angle_reset and rate_valid in the same cycle -> sample dropped, acc 0, no angle_valid; recal+angle_reset together -> CAL, calibrated 0.
REQ-039 system_reset asserted after 100 calibration samples -> all outputs 0 immediately; 256 new samples needed before calibrated.
